imem_boot_loader: RTL and testbench

- Writer side of the instruction memory. The processor core only ever reads instruction memory; this block fills it.
- Consumes a byte stream over a valid/ready handshake (for example from a UART receiver) and assembles big-endian 32-bit instruction words.
- Writes each word through the instruction-memory write port.
- Holds the core in reset until a complete, checksum-verified image is loaded.

---
 rtl/imem_boot_loader.sv | 105 ++++++++++
 tb/tb_imem_boot_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: assembles a length-prefixed, XOR-checked byte
// stream into big-endian 32-bit words and holds the core in reset until it verifies.
module imem_boot_loader #(
   parameter int          MAX_WORDS = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wd,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;

   localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

   state_t      state;
   state_t      state_nx;
   logic        rdy;
   logic        rdy_nx;
   logic [7:0]  len_hi;
   logic [15:0] len;
   logic [23:0] shift;
   logic [1:0]  byte_cnt;
   logic [7:0]  xor_acc;
   logic        accept;
   logic [15:0] len_nx;
   logic        word_end;
   logic        last_word;

   assign accept    = in_valid && rdy;
   assign len_nx    = {len_hi, in_data};
   assign word_end  = accept && (state == DATA) && (byte_cnt == 2'd3);
   assign last_word = (words_loaded == len - 16'd1);

   always_comb begin
      state_nx = state;
      case (state)
         LEN_HI: if (accept) state_nx = LEN_LO;
         LEN_LO: begin
            if (accept) begin
               if (len_nx == 16'd0)         state_nx = CHECK;
               else if (len_nx > MAX_W16)   state_nx = ERROR;
               else                         state_nx = DATA;
            end
         end
         DATA:   if (word_end && last_word) state_nx = CHECK;
         CHECK:  if (accept) state_nx = (in_data == xor_acc) ? DONE : ERROR;
         default: state_nx = state;
      endcase
      rdy_nx = (state_nx != DONE) && (state_nx != ERROR);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state        <= LEN_HI;
         rdy          <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= BASE_ADDR;
         imem_wd      <= 32'd0;
         words_loaded <= 16'd0;
         byte_cnt     <= 2'd0;
         xor_acc      <= 8'd0;
      end else begin
         state   <= state_nx;
         rdy     <= rdy_nx;
         imem_we <= word_end;
         if (accept && (state == LEN_HI || state == LEN_LO || state == DATA))
            xor_acc <= xor_acc ^ in_data;
         if (accept && state == DATA)
            byte_cnt <= byte_cnt + 2'd1;
         // address uses the pre-increment count; words_loaded advances with the write
         if (word_end) begin
            imem_addr    <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
            imem_wd      <= {shift, in_data};
            words_loaded <= words_loaded + 16'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         case (state)
            LEN_HI:  len_hi <= in_data;
            LEN_LO:  len    <= len_nx;
            DATA:    shift  <= {shift[15:0], in_data};
            default: ;
         endcase
      end
   end

   assign in_ready   = rdy;
   assign cpu_reset  = (state != DONE);
   assign load_done  = (state == DONE);
   assign load_error = (state == ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a byte-index reference model predicts every output
// each cycle, plus fixed-stream scenarios with literal expectations.
module tb_imem_boot_loader;

   localparam int          MAXW = 64;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wd;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;
   logic [15:0] words_loaded;

   imem_boot_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
      .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wd(imem_wd), .cpu_reset(cpu_reset), .load_done(load_done),
      .load_error(load_error), .words_loaded(words_loaded)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: everything derives from the index of the accepted byte.
   bit          armed = 0;
   int          m_cnt, m_n, m_words, m_status;  // status 0 loading, 1 done, 2 error
   logic [7:0]  m_hi, m_acc, m_b;
   logic [31:0] m_word, m_addr, m_wd;
   bit          m_ready, m_we;

   always @(posedge CLK) begin
      if (Reset) begin
         armed = 1; m_cnt = 0; m_n = 0; m_words = 0; m_status = 0;
         m_acc = 8'd0; m_word = 32'd0; m_ready = 0; m_we = 0;
         m_addr = BASE; m_wd = 32'd0;
      end else begin
         m_we = 0;
         if (m_ready && in_valid) begin
            m_b = in_data;
            if (m_cnt == 0) m_hi = m_b;
            else if (m_cnt == 1) begin
               m_n = int'({m_hi, m_b});
               if (m_n > MAXW) m_status = 2;
            end else if (m_cnt < 2 + 4 * m_n) begin
               m_word = {m_word[23:0], m_b};
               if ((m_cnt - 2) % 4 == 3) begin
                  m_we = 1; m_addr = BASE + 32'(4 * m_words); m_wd = m_word; m_words++;
               end
            end else m_status = (m_b == m_acc) ? 1 : 2;
            if (m_cnt < 2 || m_cnt < 2 + 4 * m_n) m_acc = m_acc ^ m_b;
            m_cnt++;
         end
         m_ready = (m_status == 0);
      end
   end

   logic [31:0] wlog_addr[$];
   logic [31:0] wlog_wd[$];

   always @(negedge CLK) begin
      if (armed) begin
         chk("in_ready", 32'(in_ready), 32'(m_ready));
         chk("imem_we", 32'(imem_we), 32'(m_we));
         if (m_we) begin
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_wd", imem_wd, m_wd);
         end
         chk("cpu_reset", 32'(cpu_reset), 32'(m_status != 1));
         chk("load_done", 32'(load_done), 32'(m_status == 1));
         chk("load_error", 32'(load_error), 32'(m_status == 2));
         chk("words_loaded", 32'(words_loaded), 32'(m_words));
         if (imem_we === 1'b1) begin
            wlog_addr.push_back(imem_addr);
            wlog_wd.push_back(imem_wd);
         end
      end
   end

   task automatic step();
      @(posedge CLK); #2;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit r, got;
      repeat (gap) begin in_valid = 1'b0; in_data = 8'($urandom); step(); end
      in_valid = 1'b1; in_data = b; got = 0;
      for (int k = 0; k < 16 && !got; k++) begin
         @(negedge CLK); r = in_ready;
         step();
         if (r) got = 1;
      end
      in_valid = 1'b0; in_data = 8'($urandom);
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: byte %h not accepted, required acceptance within 16 cycles", b);
      end
   endtask

   task automatic drive_ignored(input int cycles);
      repeat (cycles) begin in_valid = 1'b1; in_data = 8'($urandom); step(); end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; Reset = 1'b1;
      repeat (2) step();
      Reset = 1'b0;
      wlog_addr.delete(); wlog_wd.delete();
   endtask

   logic [7:0] strm[$];

   task automatic play(input int gap, input bit rand_gap);
      foreach (strm[i]) send_byte(strm[i], rand_gap ? int'($urandom_range(0, 4)) : gap);
      repeat (3) step();
   endtask

   task automatic nominal(input logic [7:0] chkbyte);
      strm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, chkbyte};
   endtask

   task automatic chk_nominal_writes(input string tag);
      chk({tag, "_nwrites"}, 32'(wlog_addr.size()), 32'd2);
      if (wlog_addr.size() == 2) begin
         chk({tag, "_addr0"}, wlog_addr[0], 32'h0000_0000);
         chk({tag, "_wd0"},   wlog_wd[0],   32'h2008_0005);
         chk({tag, "_addr1"}, wlog_addr[1], 32'h0000_0004);
         chk({tag, "_wd1"},   wlog_wd[1],   32'h0109_5020);
      end
   endtask

   initial begin
      int n;
      logic [7:0] x, d;
      #200000;
      $display("FAIL watchdog: simulation still running at 200000 time units, required completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] x, d;
      step();
      do_reset();
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_words", 32'(words_loaded), 32'd0);

      // XOR of the ten bytes before the check byte is 0x57
      nominal(8'h57); play(0, 0);
      chk_nominal_writes("nom");
      chk("nom_done", 32'(load_done), 32'd1);
      chk("nom_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("nom_words", 32'(words_loaded), 32'd2);
      chk("nom_ready", 32'(in_ready), 32'd0);

      do_reset();
      nominal(8'h07); play(0, 0);
      chk_nominal_writes("badchk");
      chk("badchk_err", 32'(load_error), 32'd1);
      chk("badchk_done", 32'(load_done), 32'd0);
      chk("badchk_cpu_reset", 32'(cpu_reset), 32'd1);

      do_reset();
      strm = '{8'h00, 8'h41}; play(0, 0);
      drive_ignored(6);
      chk("ovf_err", 32'(load_error), 32'd1);
      chk("ovf_ready", 32'(in_ready), 32'd0);
      chk("ovf_nwrites", 32'(wlog_addr.size()), 32'd0);

      do_reset();
      strm = '{8'h00, 8'h00, 8'h00}; play(1, 0);
      chk("zero_done", 32'(load_done), 32'd1);
      chk("zero_words", 32'(words_loaded), 32'd0);
      chk("zero_nwrites", 32'(wlog_addr.size()), 32'd0);
      do_reset();
      strm = '{8'h00, 8'h00, 8'h01}; play(0, 0);
      chk("zero_bad_err", 32'(load_error), 32'd1);

      do_reset();
      nominal(8'h57); play(3, 0);
      chk_nominal_writes("gap");
      chk("gap_done", 32'(load_done), 32'd1);
      chk("gap_words", 32'(words_loaded), 32'd2);

      do_reset();
      nominal(8'h57);
      for (int i = 0; i < 6; i++) send_byte(strm[i], 0);
      Reset = 1'b1; step(); Reset = 1'b0;
      chk("midrst_we", 32'(imem_we), 32'd0);
      chk("midrst_words", 32'(words_loaded), 32'd0);
      chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("midrst_ready", 32'(in_ready), 32'd0);
      chk("midrst_addr", imem_addr, BASE);
      chk("midrst_wd", imem_wd, 32'd0);
      wlog_addr.delete(); wlog_wd.delete();
      play(0, 0);
      chk_nominal_writes("replay");
      chk("replay_done", 32'(load_done), 32'd1);
      chk("replay_words", 32'(words_loaded), 32'd2);

      for (int it = 0; it < 25; it++) begin
         do_reset();
         n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXW + 1, MAXW + 8))
                                         : int'($urandom_range(0, 6));
         strm.delete();
         strm.push_back(8'(n >> 8)); strm.push_back(8'(n));
         x = 8'(n >> 8) ^ 8'(n);
         if (n <= MAXW) begin
            for (int j = 0; j < 4 * n; j++) begin
               d = 8'($urandom); strm.push_back(d); x = x ^ d;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            strm.push_back(x);
         end
         play(0, 1);
         if (n > MAXW) drive_ignored(3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
